usb_bulk_in_arbiter: RTL and testbench

Shares the single bulk-IN data path of the USB transfer layer (bid_has_data / bid_tvalid / bid_tready / bid_tlast / bid_tdata) between NUM_SRC on-chip AXI-stream packet sources, each bound to one bulk IN endpoint number.
- On each host IN transaction (blk_in_xfer with blk_xfer_endpoint), selects the matching source and forwards exactly one packet.
- Enforces MAX_PACKET_SIZE by forcing tlast.
- Re-aligns a source to its packet boundary when a transaction aborts mid-packet.
- Sits between the USB top-level bid_* inputs and the application FIFOs.

---
 rtl/usb_defs_pkg.sv | 7 +
 rtl/usb_ep_match.sv | 22 ++
 rtl/usb_bulk_in_arbiter.sv | 117 +++++++++++
 tb/tb_usb_bulk_in_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/usb_defs_pkg.sv
// usb_defs_pkg: shared USB bulk-IN arbiter state encoding and protocol constants
package usb_defs_pkg;
   localparam int EP_W       = 4;
   localparam int HS_MAX_PKT = 512;
   localparam int FS_MAX_PKT = 64;
   typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_DRAIN, ST_DONE} arb_state_t;
endpackage

// File: rtl/usb_ep_match.sv
// usb_ep_match: maps an endpoint number to the lowest-indexed source bound to it
module usb_ep_match
   import usb_defs_pkg::*;
#(
   parameter int                      NUM_SRC = 2,
   parameter logic [EP_W*NUM_SRC-1:0] EP_LIST = {4'd2, 4'd1}
) (
   input  logic [EP_W-1:0] ep,
   output logic            hit,
   output logic [2:0]      idx
);
   // scan from the top down so the lowest matching index is the one left standing
   always_comb begin
      hit = 1'b0;
      idx = 3'd0;
      for (int i = NUM_SRC - 1; i >= 0; i--)
         if (EP_LIST[EP_W*i +: EP_W] == ep) begin
            hit = 1'b1;
            idx = 3'(i);
         end
   end
endmodule

// File: rtl/usb_bulk_in_arbiter.sv
// usb_bulk_in_arbiter: shares the bulk-IN data path among per-endpoint packet sources
module usb_bulk_in_arbiter
   import usb_defs_pkg::*;
#(
   parameter int                      NUM_SRC         = 2,
   parameter logic [EP_W*NUM_SRC-1:0] EP_LIST         = {4'd2, 4'd1},
   parameter int                      MAX_PACKET_SIZE = HS_MAX_PKT,
   parameter int                      CNT_W           = $clog2(MAX_PACKET_SIZE + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 blk_in_xfer_i,
   input  logic [EP_W-1:0]      blk_xfer_endpoint_i,
   output logic                 has_data_o,
   output logic                 m_tvalid_o,
   input  logic                 m_tready_i,
   output logic                 m_tlast_o,
   output logic [7:0]           m_tdata_o,
   input  logic [NUM_SRC-1:0]   s_has_data_i,
   input  logic [NUM_SRC-1:0]   s_tvalid_i,
   output logic [NUM_SRC-1:0]   s_tready_o,
   input  logic [NUM_SRC-1:0]   s_tlast_i,
   input  logic [8*NUM_SRC-1:0] s_tdata_i,
   output logic                 sel_valid_o,
   output logic [2:0]           sel_index_o,
   output logic                 abort_o
);
   arb_state_t         state, state_nx;
   logic               xfer_q, start, hit, beat, at_max;
   logic [2:0]         sel, idx;
   logic [CNT_W-1:0]   count;
   logic               sel_has, sel_vld, sel_lst;
   logic [7:0]         sel_dat;
   logic [NUM_SRC-1:0] sel_hot;

   usb_ep_match #(.NUM_SRC(NUM_SRC), .EP_LIST(EP_LIST)) u_match (
      .ep (blk_xfer_endpoint_i),
      .hit(hit),
      .idx(idx)
   );

   assign start       = blk_in_xfer_i & ~xfer_q;
   assign at_max      = count == CNT_W'(MAX_PACKET_SIZE - 1);
   assign sel_valid_o = (state == ST_ACTIVE) | (state == ST_DRAIN);
   assign sel_index_o = sel;

   // pick the selected source's stream signals and build its one-hot ready lane
   always_comb begin
      sel_has = 1'b0;
      sel_vld = 1'b0;
      sel_lst = 1'b0;
      sel_dat = 8'd0;
      sel_hot = '0;
      for (int i = 0; i < NUM_SRC; i++)
         if (sel == 3'(i)) begin
            sel_has    = s_has_data_i[i];
            sel_vld    = s_tvalid_i[i];
            sel_lst    = s_tlast_i[i];
            sel_dat    = s_tdata_i[8*i +: 8];
            sel_hot[i] = 1'b1;
         end
   end

   // transaction FSM: forward one packet per IN, split at max size, drain on abort
   always_comb begin
      state_nx   = state;
      has_data_o = 1'b0;
      m_tvalid_o = 1'b0;
      m_tlast_o  = 1'b0;
      m_tdata_o  = 8'd0;
      s_tready_o = '0;
      abort_o    = 1'b0;
      beat       = 1'b0;
      case (state)
         ST_IDLE:
            if (start) state_nx = hit ? ST_ACTIVE : ST_DONE;
         ST_ACTIVE: begin
            has_data_o = sel_has;
            m_tvalid_o = sel_vld;
            m_tlast_o  = sel_lst | at_max;
            m_tdata_o  = sel_dat;
            s_tready_o = m_tready_i ? sel_hot : '0;
            beat       = sel_vld & m_tready_i;
            if (beat & m_tlast_o) state_nx = ST_DONE;
            else if (!blk_in_xfer_i) begin
               state_nx = (count == '0) ? ST_IDLE : ST_DRAIN;
               abort_o  = count != '0;
            end
         end
         ST_DRAIN: begin
            s_tready_o = sel_hot;
            beat       = sel_vld;
            if (beat & (sel_lst | at_max)) state_nx = ST_IDLE;
         end
         ST_DONE:
            if (!blk_in_xfer_i) state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // state, transaction edge detect, selection latch and per-segment byte counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         xfer_q <= 1'b0;
         sel    <= 3'd0;
         count  <= '0;
      end else begin
         state  <= state_nx;
         xfer_q <= blk_in_xfer_i;
         if (state == ST_IDLE && start && hit) begin
            sel   <= idx;
            count <= '0;
         end else if (beat) count <= count + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_usb_bulk_in_arbiter.sv
// tb_usb_bulk_in_arbiter: randomized IN transactions checked against a packet-segment model
module tb_usb_bulk_in_arbiter;
   localparam int N   = 2;
   localparam int MPS = 64;

   logic           clk = 1'b0;
   logic           rst_n = 1'b1;
   logic           blk_in_xfer = 1'b0;
   logic [3:0]     ep = 4'd0;
   logic           has_data, m_tvalid, m_tlast, sel_valid, abort;
   logic           m_tready = 1'b0;
   logic [7:0]     m_tdata;
   logic [N-1:0]   s_has = '0, s_tvalid = '0, s_tlast = '0, s_tready;
   logic [8*N-1:0] s_tdata = '0;
   logic [2:0]     sel_index;

   always #5 clk = ~clk;

   // source 0 answers EP2, source 1 answers EP1
   usb_bulk_in_arbiter #(
      .NUM_SRC(N), .EP_LIST({4'd1, 4'd2}), .MAX_PACKET_SIZE(MPS)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .blk_in_xfer_i(blk_in_xfer), .blk_xfer_endpoint_i(ep),
      .has_data_o(has_data), .m_tvalid_o(m_tvalid), .m_tready_i(m_tready),
      .m_tlast_o(m_tlast), .m_tdata_o(m_tdata),
      .s_has_data_i(s_has), .s_tvalid_i(s_tvalid), .s_tready_o(s_tready),
      .s_tlast_i(s_tlast), .s_tdata_i(s_tdata),
      .sel_valid_o(sel_valid), .sel_index_o(sel_index), .abort_o(abort)
   );

   logic [8:0] strm [N][$];
   int         rd [N];
   logic [8:0] cap [$];
   int         checks = 0, failures = 0;
   int         aborts, bad_other, bad_drain, bad_hd, tsrc;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic push_pkt(input int s, input int len, input bit fixed_a);
      for (int j = 0; j < len; j++)
         strm[s].push_back({j == len - 1, fixed_a ? 8'hA0 + 8'(j) : 8'($urandom)});
   endtask

   // bytes the next IN on source s should carry: to packet end, capped at MPS
   function automatic int seg_len(input int s);
      int n = 0;
      for (int j = rd[s]; j < strm[s].size(); j++) begin
         n++;
         if (strm[s][j][8] || n == MPS) break;
      end
      return n;
   endfunction

   task automatic step(input bit xf, input bit rdy);
      @(negedge clk);
      blk_in_xfer = xf;
      m_tready    = rdy;
      for (int i = 0; i < N; i++) begin
         s_has[i] = rd[i] < strm[i].size();
         if (s_has[i] && $urandom_range(3) != 0) begin
            s_tvalid[i] = 1'b1;
            {s_tlast[i], s_tdata[8*i +: 8]} = strm[i][rd[i]];
         end else begin
            s_tvalid[i] = 1'b0;
            s_tlast[i]  = 1'b0;
            s_tdata[8*i +: 8] = 8'($urandom);
         end
      end
      #1;
      for (int i = 0; i < N; i++) begin
         if (s_tvalid[i] && s_tready[i]) rd[i]++;
         if (s_tready[i] && i != tsrc) bad_other++;
      end
      if (m_tvalid && m_tready) cap.push_back({m_tlast, m_tdata});
      if (abort) aborts++;
      if (tsrc < 0 && (has_data || sel_valid)) bad_hd++;
   endtask

   task automatic run_in(input logic [3:0] e, input int abort_k, input int mode);
      int s = (e == 4'd2) ? 0 : (e == 4'd1) ? 1 : -1;
      int l = 0, st = 0, target, cyc, bad;
      bit tog = 1'b0, rdy;
      cap.delete();
      aborts = 0; bad_other = 0; bad_drain = 0; bad_hd = 0;
      tsrc = s;
      ep = e;
      if (s >= 0) begin
         st = rd[s];
         l  = seg_len(s);
         if (abort_k < 0) abort_k = (l > 1 && $urandom_range(2) == 0) ? $urandom_range(1, l - 1) : 0;
      end
      step(1, 0);
      step(1, 0);
      check("sel_valid", 32'(sel_valid), 32'(s >= 0));
      check("has_data", 32'(has_data), 32'(s >= 0));
      if (s < 0) begin
         repeat (6) step(1, 1);
         step(0, 0);
         step(0, 0);
         check("unmapped_quiet", bad_hd + bad_other + cap.size(), 0);
         check("unmapped_idle", 32'(sel_valid), 0);
         return;
      end
      check("sel_index", 32'(sel_index), 32'(s));
      target = (abort_k > 0) ? abort_k : l;
      cyc = 0;
      while (cap.size() < target && cyc < 3000) begin
         rdy = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(1)) : tog;
         tog = ~tog;
         step(1, rdy);
         cyc++;
      end
      check("beats", cap.size(), target);
      step(0, 0);
      cyc = 0;
      while (sel_valid && cyc < 3000) begin
         step(0, 0);
         if (m_tvalid) bad_drain++;
         cyc++;
      end
      step(0, 0);
      check("idle_after", 32'(sel_valid), 0);
      bad = 0;
      for (int j = 0; j < cap.size(); j++)
         if (cap[j] !== {j == l - 1, strm[s][st + j][7:0]}) bad++;
      check("data", bad, 0);
      check("consumed", rd[s] - st, l);
      check("abort_pulses", aborts, 32'(abort_k > 0));
      check("other_tready", bad_other, 0);
      check("drain_valid", bad_drain, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int e, md;
      push_pkt(1, 4, 1'b1);
      push_pkt(0, 100, 1'b0);
      push_pkt(0, 20, 1'b0);
      for (int k = 0; k < 60; k++) begin
         push_pkt(0, $urandom_range(1, 150), 1'b0);
         push_pkt(1, $urandom_range(1, 150), 1'b0);
      end
      tsrc = -2;
      #2 rst_n = 1'b0;
      #1;
      check("reset_outs", 32'({has_data, m_tvalid, m_tlast, m_tdata, s_tready, sel_valid, sel_index, abort}), 0);
      repeat (3) step(0, 0);
      rst_n = 1'b1;
      run_in(4'd1, 0, 0);
      run_in(4'd2, 0, 0);
      run_in(4'd2, 0, 0);
      run_in(4'd2, 5, 0);
      run_in(4'd2, 0, 1);
      run_in(4'd5, 0, 0);
      run_in(4'd1, 0, 2);
      for (int k = 0; k < 24; k++) begin
         md = $urandom_range(2);
         case ($urandom_range(4))
            0: e = 5;
            1, 2: e = 1;
            default: e = 2;
         endcase
         run_in(4'(e), -1, md);
      end
      tsrc = 0;
      ep = 4'd2;
      step(1, 0);
      repeat (3) step(1, 1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_outs", 32'({has_data, m_tvalid, m_tlast, m_tdata, s_tready, sel_valid, sel_index, abort}), 0);
      step(0, 0);
      rst_n = 1'b1;
      step(0, 0);
      step(0, 0);
      check("idle_after_reset", 32'({sel_valid, has_data, m_tvalid, s_tready}), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
